// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue; flush empties it in one edge and wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_data,
    output fetch_entry_t             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [AW-1:0]    r_rdPtr;
    logic [AW-1:0]    r_wrPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];
    // A push on a full queue is only accepted when the head leaves the same cycle.
    assign w_doPush = i_push && (!o_full || i_pop);
    assign w_doPop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding bus request feeding a FIFO toward decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t   r_state;
    fetch_state_t   w_stateNext;
    logic           r_memReq;
    logic [31:0]    r_memAddr;
    logic [31:0]    r_fetchPc;
    logic [31:0]    w_fetchPcNext;
    logic [31:0]    w_addrNext;
    logic           w_reqNext;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_countNext;
    logic           w_canIssue;
    fetch_entry_t   w_pushData;
    fetch_entry_t   w_head;

    assign w_push     = (r_state == WAIT) && i_mem_ready && !i_redirect;
    assign w_pop      = !w_empty && !i_stall && !i_redirect;
    assign w_pushData = '{pc: r_memAddr, instr: i_mem_rdata};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_redirect),
        .i_data  (w_pushData),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Occupancy after this edge decides whether another request may be issued.
    always_comb begin
        w_countNext = w_count;
        if (w_push && !w_pop) w_countNext = w_count + 1'b1;
        if (w_pop && !w_push) w_countNext = w_count - 1'b1;
        if (i_redirect)       w_countNext = '0;
        w_canIssue = (w_countNext < CW'(DEPTH));
    end

    always_comb begin
        w_fetchPcNext = r_fetchPc;
        if (i_redirect) begin
            w_fetchPcNext = {i_redirect_pc[31:2], 2'b00};
        end else if (w_push) begin
            w_fetchPcNext = r_fetchPc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (i_redirect || w_canIssue) w_stateNext = WAIT;
            end
            WAIT: begin
                if (i_mem_ready) begin
                    w_stateNext = (i_redirect || w_canIssue) ? WAIT : IDLE;
                end else if (i_redirect) begin
                    w_stateNext = DISCARD;
                end
            end
            DISCARD: begin
                if (i_mem_ready) begin
                    w_stateNext = (i_redirect || w_canIssue) ? WAIT : IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // A new address is launched only when a request starts fresh or the previous one completed.
    always_comb begin
        w_reqNext  = (w_stateNext != IDLE);
        w_addrNext = r_memAddr;
        if (w_stateNext == WAIT && (r_state == IDLE || i_mem_ready)) begin
            w_addrNext = w_fetchPcNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memReq  <= 1'b0;
            r_memAddr <= RESET_PC;
            r_fetchPc <= RESET_PC;
        end else begin
            r_memReq  <= w_reqNext;
            r_memAddr <= w_addrNext;
            r_fetchPc <= w_fetchPcNext;
        end
    end

    assign o_mem_req     = r_memReq;
    assign o_mem_addr    = r_memAddr;
    assign o_instr       = w_head.instr;
    assign o_instr_pc    = w_head.pc;
    assign o_instr_valid = !w_empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns the bitwise inverse of the address.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memReady = 1'b0;
    logic [31:0] memRdata;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic        instrValid;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    assign memRdata = ~memAddr;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .o_mem_req     (memReq),
        .o_mem_addr    (memAddr),
        .i_mem_ready   (memReady),
        .i_mem_rdata   (memRdata),
        .i_redirect    (redirect),
        .i_redirect_pc (redirectPc),
        .i_stall       (stall),
        .o_instr       (instr),
        .o_instr_pc    (instrPc),
        .o_instr_valid (instrValid)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic stl, input logic redir, input logic [31:0] rpc);
        memReady   = ready;
        stall      = stl;
        redirect   = redir;
        redirectPc = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut(input logic ready, input logic stl);
        applyStimulus(ready, stl, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values, asserted asynchronously away from any edge
        #1 rst = 1'b1;
        #2;
        checkOutput("rst_req", {31'b0, memReq}, 32'd0);
        checkOutput("rst_addr", memAddr, 32'h0);
        checkOutput("rst_valid", {31'b0, instrValid}, 32'd0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_pc", instrPc, 32'h0);

        // Zero-wait streaming
        resetDut(1'b1, 1'b0);
        tick();
        checkOutput("stream_req0", {31'b0, memReq}, 32'd1);
        checkOutput("stream_addr0", memAddr, 32'h0);
        checkOutput("stream_valid0", {31'b0, instrValid}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput("stream_addr", memAddr, 32'(i * 4));
            checkOutput("stream_pc", instrPc, 32'((i - 1) * 4));
            checkOutput("stream_instr", instr, ~32'((i - 1) * 4));
        end
        tick();
        checkOutput("stream_pc3", instrPc, 32'hC);
        checkOutput("stream_valid3", {31'b0, instrValid}, 32'd1);

        // Stall fills the queue, then drains in order
        resetDut(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("fill_req", {31'b0, memReq}, 32'd0);
        checkOutput("fill_pc0", instrPc, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("drain_req", {31'b0, memReq}, 32'd1);
        checkOutput("drain_addr", memAddr, 32'h10);
        checkOutput("drain_pc4", instrPc, 32'h4);
        tick();
        checkOutput("drain_pc8", instrPc, 32'h8);
        tick();
        checkOutput("drain_pcC", instrPc, 32'hC);
        tick();
        checkOutput("drain_pc10", instrPc, 32'h10);
        checkOutput("drain_instr10", instr, ~32'h10);

        // Redirect while waiting on a slow response
        resetDut(1'b0, 1'b0);
        tick();
        checkOutput("slow_addr0", memAddr, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("disc_req", {31'b0, memReq}, 32'd1);
        checkOutput("disc_addr", memAddr, 32'h0);
        tick();
        checkOutput("disc_hold", memAddr, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("disc_newaddr", memAddr, 32'h100);
        checkOutput("disc_nodata", {31'b0, instrValid}, 32'd0);
        tick();
        checkOutput("disc_pc", instrPc, 32'h100);
        checkOutput("disc_valid", {31'b0, instrValid}, 32'd1);

        // Redirect coinciding with pop and push on a two-entry queue
        resetDut(1'b1, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("two_pc0", instrPc, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0203);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("flush_valid", {31'b0, instrValid}, 32'd0);
        checkOutput("flush_addr", memAddr, 32'h200);
        tick();
        checkOutput("flush_pc", instrPc, 32'h200);
        checkOutput("flush_instr", instr, ~32'h200);

        // Address wrap past the top of memory
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_addr", memAddr, 32'hFFFF_FFF8);
        tick();
        checkOutput("wrap_pc0", instrPc, 32'hFFFF_FFF8);
        tick();
        checkOutput("wrap_pc1", instrPc, 32'hFFFF_FFFC);
        tick();
        checkOutput("wrap_pc2", instrPc, 32'h0000_0000);
        checkOutput("wrap_instr2", instr, 32'hFFFF_FFFF);

        // Reset during an outstanding request with entries queued
        resetDut(1'b1, 1'b1);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_valid", {31'b0, instrValid}, 32'd0);
        checkOutput("midrst_req", {31'b0, memReq}, 32'd0);
        checkOutput("midrst_addr", memAddr, 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("restart_req", {31'b0, memReq}, 32'd1);
        checkOutput("restart_addr", memAddr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
